// File: rtl/step_if.sv
// Command, divisor and status bundle between a debug host and the step controller.
interface step_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
);
  logic             cmd_run;
  logic             cmd_step;
  logic             cmd_stop;
  logic             halt_in;
  logic             div_we;
  logic [DIV_W-1:0] div_value;
  logic             cpu_en;
  logic [1:0]       state;
  logic [DIV_W-1:0] div_active;
  logic [CNT_W-1:0] tick_count;

  modport master (
    output cmd_run, cmd_step, cmd_stop, halt_in, div_we, div_value,
    input  cpu_en, state, div_active, tick_count
  );

  modport slave (
    input  cmd_run, cmd_step, cmd_stop, halt_in, div_we, div_value,
    output cpu_en, state, div_active, tick_count
  );
endinterface

// File: rtl/step_controller.sv
// Run/step/halt controller issuing prescaled single-cycle CPU clock enables.
//
//   state  | meaning
//   IDLE   | waiting for cmd_run / cmd_step, divisor writable
//   RUN    | free-running, cpu_en every div_active cycles
//   STEP   | one cpu_en after div_active cycles, then back to IDLE
//   HALTED | CPU requested halt, only cmd_stop leaves, divisor writable
module step_controller #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CNT_W       = 32
) (
  input logic  clk_in,
  input logic  rst,
  step_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] pre_cnt;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] tick_q;
  logic             active;
  logic             next_active;
  logic             pre_last;
  logic             cpu_en;

  assign active      = (state_q == S_RUN) || (state_q == S_STEP);
  assign next_active = (state_d == S_RUN) || (state_d == S_STEP);
  assign pre_last    = (pre_cnt == (div_q - DIV_W'(1)));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.cmd_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_step)     state_d = S_STEP;
          else if (bus.cmd_run) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.halt_in) state_d = S_HALTED;
        end
        S_STEP: begin
          if (bus.halt_in)  state_d = S_HALTED;
          else if (pre_last) state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cpu_en = active && pre_last;
  end

  // Staying in RUN/STEP advances the prescaler; any entry or exit restarts it at 0.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (next_active && (state_d == state_q)) begin
      pre_cnt <= pre_last ? '0 : pre_cnt + DIV_W'(1);
    end else begin
      pre_cnt <= '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_q <= DIV_W'(DEFAULT_DIV);
    end else if (bus.div_we && !active) begin
      div_q <= (bus.div_value == '0) ? DIV_W'(1) : bus.div_value;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)         tick_q <= '0;
    else if (cpu_en) tick_q <= tick_q + CNT_W'(1);
  end

  assign bus.cpu_en     = cpu_en;
  assign bus.state      = state_q;
  assign bus.div_active = div_q;
  assign bus.tick_count = tick_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed and randomized checks of step_controller against a cycle-index reference model.
module tb_step_controller;

  localparam int DIV_W = 16;
  localparam int CNT_W = 32;

  logic clk_in;
  logic rst;
  int   vecs;
  int   errs;

  step_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  step_controller #(.DIV_W(DIV_W), .DEFAULT_DIV(2), .CNT_W(CNT_W)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // reference model: age = index of current cycle since entering RUN/STEP (first cycle = 1)
  int          m_state;
  int          m_age;
  int          m_div;
  logic [31:0] m_ticks;

  function automatic bit model_en();
    return ((m_state == 1) || (m_state == 2)) && ((m_age % m_div) == 0);
  endfunction

  task automatic model_edge(input bit run, input bit step, input bit stop,
                            input bit halt, input bit we, input int val);
    bit en;
    int nxt;
    en  = model_en();
    nxt = m_state;
    if (en) m_ticks = m_ticks + 1;
    if (stop) nxt = 0;
    else if (m_state == 0) begin
      if (step) nxt = 2;
      else if (run) nxt = 1;
    end else if (m_state == 1) begin
      if (halt) nxt = 3;
    end else if (m_state == 2) begin
      if (halt) nxt = 3;
      else if (en) nxt = 0;
    end
    if (we && (m_state == 0 || m_state == 3)) m_div = (val == 0) ? 1 : val;
    if (nxt == 1 || nxt == 2) m_age = (nxt == m_state) ? m_age + 1 : 1;
    else m_age = 0;
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cmd_run = 0; bus.cmd_step = 0; bus.cmd_stop = 0;
    bus.halt_in = 0; bus.div_we = 0; bus.div_value = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk_in);
    rst = 1'b1;
    #2;
    @(negedge clk_in);
    rst = 1'b0;
    tick();
  endtask

  task automatic write_div(input int v);
    bus.div_we = 1; bus.div_value = DIV_W'(v);
    tick();
    bus.div_we = 0; bus.div_value = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    vecs++;
    if (bus.state !== 2'b00 || bus.cpu_en !== 1'b0 || bus.tick_count !== '0 || bus.div_active !== 16'd2) begin
      $display("FAIL reset_values: got state=%0d en=%b ticks=%0d div=%0d want 0 0 0 2",
               bus.state, bus.cpu_en, bus.tick_count, bus.div_active);
      errs++;
    end
    @(negedge clk_in);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_run_div4();
    do_reset();
    write_div(4);
    bus.cmd_run = 1; tick(); bus.cmd_run = 0;
    for (int k = 1; k <= 12; k++) begin
      vecs++;
      if (bus.cpu_en !== ((k % 4) == 0)) begin
        $display("FAIL run4_en cycle %0d: got %b want %b", k, bus.cpu_en, ((k % 4) == 0));
        errs++;
      end
      tick();
    end
    vecs++;
    if (bus.tick_count !== 32'd3) begin
      $display("FAIL run4_ticks: got %0d want 3", bus.tick_count);
      errs++;
    end
  endtask

  task automatic test_step();
    do_reset();
    write_div(3);
    for (int n = 1; n <= 2; n++) begin
      bus.cmd_step = 1; tick(); bus.cmd_step = 0;
      for (int k = 1; k <= 3; k++) begin
        vecs++;
        if (bus.cpu_en !== (k == 3) || bus.state !== 2'b10) begin
          $display("FAIL step_en n=%0d cycle %0d: got en=%b state=%0d want en=%b state=2",
                   n, k, bus.cpu_en, bus.state, (k == 3));
          errs++;
        end
        tick();
      end
      vecs++;
      if (bus.state !== 2'b00 || bus.tick_count !== 32'(n)) begin
        $display("FAIL step_done n=%0d: got state=%0d ticks=%0d want 0 %0d", n, bus.state, bus.tick_count, n);
        errs++;
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.cmd_run = 1; tick(); bus.cmd_run = 0;
    tick();
    vecs++;
    if (bus.cpu_en !== 1'b1) begin
      $display("FAIL halt_pre_en: got %b want 1", bus.cpu_en);
      errs++;
    end
    bus.halt_in = 1; tick(); bus.halt_in = 0;
    vecs++;
    if (bus.state !== 2'b11 || bus.tick_count !== 32'd1) begin
      $display("FAIL halt_enter: got state=%0d ticks=%0d want 3 1", bus.state, bus.tick_count);
      errs++;
    end
    for (int k = 0; k < 10; k++) begin
      bus.cmd_run = (k == 4);
      bus.cmd_step = (k == 6);
      vecs++;
      if (bus.cpu_en !== 1'b0 || bus.state !== 2'b11) begin
        $display("FAIL halt_hold cycle %0d: got en=%b state=%0d want 0 3", k, bus.cpu_en, bus.state);
        errs++;
      end
      tick();
    end
    clear_inputs();
    bus.cmd_stop = 1; tick(); bus.cmd_stop = 0;
    vecs++;
    if (bus.state !== 2'b00 || bus.tick_count !== 32'd1) begin
      $display("FAIL halt_stop: got state=%0d ticks=%0d want 0 1", bus.state, bus.tick_count);
      errs++;
    end
  endtask

  task automatic test_div_write();
    do_reset();
    write_div(5);
    bus.cmd_run = 1; tick(); bus.cmd_run = 0;
    write_div(1);
    vecs++;
    if (bus.div_active !== 16'd5) begin
      $display("FAIL div_run_drop: got %0d want 5", bus.div_active);
      errs++;
    end
    bus.cmd_stop = 1; tick(); bus.cmd_stop = 0;
    write_div(0);
    vecs++;
    if (bus.div_active !== 16'd1 || bus.state !== 2'b00) begin
      $display("FAIL div_zero: got div=%0d state=%0d want 1 0", bus.div_active, bus.state);
      errs++;
    end
    bus.cmd_run = 1; tick(); bus.cmd_run = 0;
    for (int k = 1; k <= 5; k++) begin
      vecs++;
      if (bus.cpu_en !== 1'b1 || bus.tick_count !== 32'(k - 1)) begin
        $display("FAIL div1_run cycle %0d: got en=%b ticks=%0d want 1 %0d", k, bus.cpu_en, bus.tick_count, k - 1);
        errs++;
      end
      tick();
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.cmd_stop = 1; bus.cmd_run = 1; tick(); clear_inputs();
    vecs++;
    if (bus.state !== 2'b00) begin
      $display("FAIL prio_stop_run: got state=%0d want 0", bus.state);
      errs++;
    end
    bus.cmd_step = 1; bus.cmd_run = 1; tick(); clear_inputs();
    vecs++;
    if (bus.state !== 2'b10) begin
      $display("FAIL prio_step_run: got state=%0d want 2", bus.state);
      errs++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_div(3);
    bus.cmd_run = 1; tick(); bus.cmd_run = 0;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (bus.cpu_en !== 1'b0 || bus.state !== 2'b00 || bus.tick_count !== '0 || bus.div_active !== 16'd2) begin
      $display("FAIL async_reset: got en=%b state=%0d ticks=%0d div=%0d want 0 0 0 2",
               bus.cpu_en, bus.state, bus.tick_count, bus.div_active);
      errs++;
    end
    @(negedge clk_in);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      vecs++;
      if (bus.cpu_en !== 1'b0 || bus.state !== 2'b00) begin
        $display("FAIL post_reset_idle cycle %0d: got en=%b state=%0d want 0 0", k, bus.cpu_en, bus.state);
        errs++;
      end
    end
  endtask

  task automatic test_random();
    bit run, step, stop, halt, we;
    int val;
    do_reset();
    m_state = 0; m_age = 0; m_div = 2; m_ticks = 0;
    for (int i = 0; i < 3000; i++) begin
      stop = ($urandom_range(0, 31) == 0);
      halt = ($urandom_range(0, 23) == 0);
      step = ($urandom_range(0, 7) == 0);
      run  = ($urandom_range(0, 7) == 0);
      we   = ($urandom_range(0, 5) == 0);
      val  = $urandom_range(0, 6);
      bus.cmd_run = run; bus.cmd_step = step; bus.cmd_stop = stop;
      bus.halt_in = halt; bus.div_we = we; bus.div_value = DIV_W'(val);
      vecs++;
      if (bus.cpu_en !== model_en() || bus.state !== 2'(m_state) ||
          bus.div_active !== DIV_W'(m_div) || bus.tick_count !== m_ticks) begin
        $display("FAIL random cycle %0d: got en=%b state=%0d div=%0d ticks=%0d want en=%b state=%0d div=%0d ticks=%0d",
                 i, bus.cpu_en, bus.state, bus.div_active, bus.tick_count,
                 model_en(), m_state, m_div, m_ticks);
        errs++;
      end
      model_edge(run, step, stop, halt, we, val);
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b0;
    clear_inputs();
    test_reset();
    test_run_div4();
    test_step();
    test_halt();
    test_div_write();
    test_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter DIV_W, default 16, width of divisor register and prescaler counter.
REQ-002 Parameter DEFAULT_DIV, default 2, divisor value loaded on reset.
REQ-003 Parameter CNT_W, default 32, width of issued-enable counter.
REQ-004 clk_in  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cmd_run  input  1  single-cycle pulse, request free-running execution.
REQ-007 cmd_step  input  1  single-cycle pulse, request exactly one CPU enable.
REQ-008 cmd_stop  input  1  single-cycle pulse, return to IDLE from any state.
REQ-009 halt_in  input  1  CPU-originated halt (e.g. ebreak), sampled every cycle.
REQ-010 div_we  input  1  divisor write strobe.
REQ-011 div_value  input  DIV_W  new divisor value.
REQ-012 cpu_en  output  1  one-clk_in-cycle CPU clock-enable pulse.
REQ-013 state  output  2  current state encoding.
REQ-014 div_active  output  DIV_W  currently applied divisor.
REQ-015 tick_count  output  CNT_W  number of cpu_en pulses issued since reset.

Function
REQ-016 States SHALL be IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
REQ-017 Command priority SHALL be cmd_stop > halt_in > cmd_step > cmd_run when asserted together.
REQ-018 IDLE: cmd_step -> STEP; cmd_run -> RUN; halt_in ignored; else hold.
REQ-019 RUN: cmd_stop -> IDLE; halt_in -> HALTED; cmd_run and cmd_step ignored (no prescaler restart).
REQ-020 STEP: cmd_stop -> IDLE; halt_in -> HALTED; after its single cpu_en cycle -> IDLE; cmd_run/cmd_step ignored.
REQ-021 HALTED: only cmd_stop exits (-> IDLE); cmd_run, cmd_step, halt_in ignored.
REQ-022 Prescaler pre_cnt SHALL clear to 0 on every transition into RUN or STEP and hold at 0 in IDLE/HALTED.
REQ-023 In RUN/STEP, pre_cnt SHALL increment each cycle and wrap to 0 after reaching div_active-1.
REQ-024 cpu_en SHALL be high exactly in cycles where state is RUN or STEP and pre_cnt == div_active-1; decoded from registers only, no input feed-through.
REQ-025 Latency: with divisor D, first cpu_en SHALL be high in the D-th cycle after the edge sampling cmd_run/cmd_step; subsequent RUN pulses every D cycles.
REQ-026 D=1 SHALL yield cpu_en high every cycle in RUN and in the first cycle of STEP.
REQ-027 div_we SHALL update div_active only in IDLE or HALTED; writes in RUN/STEP are dropped.
REQ-028 Writing div_value=0 SHALL store 1.
REQ-029 halt_in coincident with cpu_en: that pulse SHALL still count; next state HALTED, no further pulses.
REQ-030 cmd_stop coincident with cpu_en: that pulse SHALL still count; next state IDLE.
REQ-031 tick_count SHALL increment by 1 on each cycle cpu_en is high and wrap modulo 2^CNT_W.

Reset
REQ-032 rst high SHALL immediately force state=IDLE, pre_cnt=0, cpu_en=0, tick_count=0, div_active=DEFAULT_DIV, independent of clk_in.
REQ-033 Reset asserted mid-RUN or mid-STEP SHALL abort with no further cpu_en; after deassertion the block waits in IDLE for a command.

Verification
REQ-034 Reset, div_we with 4 in IDLE, cmd_run -> cpu_en high in cycles 4, 8, 12 after command edge; tick_count=3 after cycle 12.
REQ-035 div_active=3, cmd_step -> single cpu_en in cycle 3, state IDLE in cycle 4, tick_count=1; second cmd_step -> tick_count=2.
REQ-036 RUN with D=2, halt_in coincident with a cpu_en -> pulse counted, state=HALTED, no cpu_en for 10 cycles; cmd_run ignored; cmd_stop -> IDLE.
REQ-037 RUN with D=5, div_we with 1 -> div_active stays 5; after cmd_stop, div_we with 0 -> div_active=1; cmd_run -> cpu_en every cycle.
REQ-038 Same-cycle cmd_stop+cmd_run in IDLE -> stays IDLE; same-cycle cmd_step+cmd_run -> STEP.
REQ-039 rst pulsed between clk_in edges during RUN -> cpu_en low, state=IDLE, tick_count=0, div_active=2 before next edge.
